toggle_cover_detector: RTL and testbench

- Per-bit toggle detector feeding a GEN_wN_toggle-style coverage reporter.
- Samples a monitored W-bit signal each enabled cycle and detects rising and falling transitions per bit.
- Keeps a sticky covered mask and emits registered one-cycle valid pulses, one per cover point, that wire directly to the reporter's valid input.
- Also keeps a running covered-point count and an all-covered flag for fuzzer feedback.

---
 rtl/toggle_cover_detector_if.sv | 25 ++
 rtl/toggle_cover_detector.sv | 78 +++++++
 tb/tb_toggle_cover_detector.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/toggle_cover_detector_if.sv
// Bundles the monitored signal, sampling controls and coverage outputs of toggle_cover_detector.
interface toggle_cover_detector_if #(
    parameter int unsigned W     = 83,
    parameter int unsigned CNT_W = $clog2(2*W+1)
);
    logic [W-1:0]     sig;
    logic             en;
    logic             clr_sticky;
    logic [2*W-1:0]   valid;
    logic [CNT_W-1:0] covered_cnt;
    logic             all_covered;
    logic             new_hit;

    // Driver side: stimulus out, coverage results in.
    modport master (
        output sig, en, clr_sticky,
        input  valid, covered_cnt, all_covered, new_hit
    );

    // Detector side.
    modport slave (
        input  sig, en, clr_sticky,
        output valid, covered_cnt, all_covered, new_hit
    );
endinterface

// File: rtl/toggle_cover_detector.sv
// Per-bit rise/fall toggle detector with sticky coverage mask, registered
// one-cycle cover pulses, covered-point count and all-covered flag.
module toggle_cover_detector #(
    parameter int unsigned W        = 83,
    parameter bit          ONLY_NEW = 1'b1,
    parameter int unsigned CNT_W    = $clog2(2*W+1)
) (
    input  logic                   gbl_clk,
    input  logic                   reset,
    toggle_cover_detector_if.slave bus
);
    localparam int unsigned NP = 2*W;

    logic [W-1:0]     prev;
    logic             prev_vld;
    logic [NP-1:0]    hit;
    logic [NP-1:0]    valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             all_q;
    logic             new_hit_q;

    logic             act;
    logic [NP-1:0]    tog;
    logic [NP-1:0]    hit_eff;
    logic [NP-1:0]    newp;
    logic [NP-1:0]    valid_next;
    logic [CNT_W-1:0] new_cnt;
    logic [CNT_W-1:0] cnt_next;

    // Edge detection against the previous enabled sample, filtering and count update.
    always_comb begin
        act        = bus.en & prev_vld;
        tog        = '0;
        for (int i = 0; i < W; i++) begin
            tog[2*i]   = act & ~prev[i] &  bus.sig[i];
            tog[2*i+1] = act &  prev[i] & ~bus.sig[i];
        end
        // A clear wipes history first so this cycle's toggles count as new.
        hit_eff    = bus.clr_sticky ? '0 : hit;
        newp       = tog & ~hit_eff;
        valid_next = ONLY_NEW ? newp : tog;
        new_cnt    = '0;
        for (int j = 0; j < NP; j++) begin
            new_cnt = new_cnt + CNT_W'(newp[j]);
        end
        cnt_next   = (bus.clr_sticky ? '0 : cnt_q) + new_cnt;
    end

    // Sample register, sticky mask and registered coverage outputs.
    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            prev      <= '0;
            prev_vld  <= 1'b0;
            hit       <= '0;
            valid_q   <= '0;
            cnt_q     <= '0;
            all_q     <= 1'b0;
            new_hit_q <= 1'b0;
        end else begin
            // prev only loads while enabled so X on a disabled sig never enters state.
            if (bus.en) begin
                prev <= bus.sig;
            end
            prev_vld  <= bus.en;
            hit       <= hit_eff | tog;
            valid_q   <= valid_next;
            new_hit_q <= |valid_next;
            cnt_q     <= cnt_next;
            all_q     <= (cnt_next == CNT_W'(NP));
        end
    end

    assign bus.valid       = valid_q;
    assign bus.covered_cnt = cnt_q;
    assign bus.all_covered = all_q;
    assign bus.new_hit     = new_hit_q;

endmodule

// File: tb/tb_toggle_cover_detector.sv
// Directed bench: runs ONLY_NEW=1 and ONLY_NEW=0 detectors (W=4) side by side on shared stimulus.
module tb_toggle_cover_detector;
    logic       gbl_clk;
    logic       reset;
    logic [3:0] sig;
    logic       en;
    logic       clr_sticky;

    int n_vec = 0;
    int n_mis = 0;

    toggle_cover_detector_if #(.W(4)) if_n ();
    toggle_cover_detector_if #(.W(4)) if_a ();

    assign if_n.sig        = sig;
    assign if_n.en         = en;
    assign if_n.clr_sticky = clr_sticky;
    assign if_a.sig        = sig;
    assign if_a.en         = en;
    assign if_a.clr_sticky = clr_sticky;

    toggle_cover_detector #(.W(4), .ONLY_NEW(1'b1)) u_new (
        .gbl_clk (gbl_clk),
        .reset   (reset),
        .bus     (if_n)
    );

    toggle_cover_detector #(.W(4), .ONLY_NEW(1'b0)) u_all (
        .gbl_clk (gbl_clk),
        .reset   (reset),
        .bus     (if_a)
    );

    initial begin
        gbl_clk = 1'b0;
        forever #5 gbl_clk = ~gbl_clk;
    end

    // Counts one comparison and reports it if observed differs from expected.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks every output of both instances.
    task automatic chk_all(input string tag, input logic [7:0] vn, input logic [7:0] va,
                           input logic [3:0] cnt, input logic all_c);
        chk({tag, " new.valid"},   32'(if_n.valid),       32'(vn));
        chk({tag, " new.cnt"},     32'(if_n.covered_cnt), 32'(cnt));
        chk({tag, " new.all"},     32'(if_n.all_covered), 32'(all_c));
        chk({tag, " new.new_hit"}, 32'(if_n.new_hit),     32'(vn != 8'h00));
        chk({tag, " all.valid"},   32'(if_a.valid),       32'(va));
        chk({tag, " all.cnt"},     32'(if_a.covered_cnt), 32'(cnt));
        chk({tag, " all.all"},     32'(if_a.all_covered), 32'(all_c));
        chk({tag, " all.new_hit"}, 32'(if_a.new_hit),     32'(va != 8'h00));
    endtask

    // Advance one edge and settle just past it.
    task automatic tick();
        @(posedge gbl_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        sig        = 4'h0;
        en         = 1'b0;
        clr_sticky = 1'b0;

        // Reset then arm.
        tick();
        tick();
        chk_all("reset", 8'h00, 8'h00, 4'd0, 1'b0);
        reset = 1'b1; en = 1'b1; sig = 4'b0000;
        tick();
        chk_all("arm", 8'h00, 8'h00, 4'd0, 1'b0);
        sig = 4'b0101;
        tick();
        chk_all("rise02", 8'h11, 8'h11, 4'd2, 1'b0);
        tick();
        chk_all("pulse_end", 8'h00, 8'h00, 4'd2, 1'b0);

        // First-sample suppression.
        do_reset();
        sig = 4'hF; en = 1'b1;
        tick();
        tick();
        tick();
        chk_all("first_sample", 8'h00, 8'h00, 4'd0, 1'b0);

        // Repeat filtering.
        do_reset();
        sig = 4'h0;
        tick();
        sig = 4'h1;
        tick();
        chk_all("rep_rise", 8'h01, 8'h01, 4'd1, 1'b0);
        sig = 4'h0;
        tick();
        chk_all("rep_fall", 8'h02, 8'h02, 4'd2, 1'b0);
        sig = 4'h1;
        tick();
        chk_all("rep_rise2", 8'h00, 8'h01, 4'd2, 1'b0);

        // Enable gap.
        do_reset();
        sig = 4'h0;
        tick();
        en = 1'b0; sig = 4'h1;
        tick();
        chk_all("gap_off", 8'h00, 8'h00, 4'd0, 1'b0);
        en = 1'b1;
        tick();
        chk_all("gap_rearm", 8'h00, 8'h00, 4'd0, 1'b0);
        tick();
        chk_all("gap_hold", 8'h00, 8'h00, 4'd0, 1'b0);
        sig = 4'h0;
        tick();
        chk_all("gap_fall", 8'h02, 8'h02, 4'd1, 1'b0);

        // Clear with simultaneous toggle.
        do_reset();
        sig = 4'h0;
        tick();
        sig = 4'b0111;
        tick();
        chk_all("clr_pre_r", 8'h15, 8'h15, 4'd3, 1'b0);
        sig = 4'b0000;
        tick();
        chk_all("clr_pre_f", 8'h2A, 8'h2A, 4'd6, 1'b0);
        sig = 4'b1000; clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk_all("clr_tog", 8'h40, 8'h40, 4'd1, 1'b0);

        // Full coverage, then mid-operation reset.
        sig = 4'b0000;
        tick();
        chk_all("full_f3", 8'h80, 8'h80, 4'd2, 1'b0);
        sig = 4'b1111;
        tick();
        chk_all("full_r", 8'h15, 8'h55, 4'd5, 1'b0);
        sig = 4'b0000;
        tick();
        chk_all("full_f", 8'h2A, 8'hAA, 4'd8, 1'b1);
        sig = 4'b1111;
        tick();
        chk_all("full_again", 8'h00, 8'h55, 4'd8, 1'b1);
        reset = 1'b0;
        tick();
        chk_all("mid_reset", 8'h00, 8'h00, 4'd0, 1'b0);
        reset = 1'b1; sig = 4'b0000;
        tick();
        chk_all("post_rst_arm", 8'h00, 8'h00, 4'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
